mmio_uart_tx: RTL and testbench

// Memory-mapped UART transmitter on the CPU data-memory bus; responder to the cpu load/store port.
// - Sits beside ram; the top level muxes rd by hit.
// - CPU stores bytes to TXDATA. Bytes queue in a FIFO and are serialised 8N1, LSB first, on tx.
// - Test programs use it as a console output.

---
 rtl/mmio_uart_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
// Register window of four words at BASE_ADDR: TXDATA, STATUS, CTRL, DIVISOR.
// Bytes stored to TXDATA are queued and shifted out LSB first on tx.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [3:0]  mask,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Register state
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             en_q, en_d;
  logic [15:0]      div_q, div_d;
  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      clk_cnt_q, clk_cnt_d;
  logic             tx_q, tx_d;

  // Decode and status helpers
  logic [1:0]       sel_s;
  logic             wr_s;
  logic             push_req_s;
  logic             push_acc_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             busy_s;
  logic             ovf_clr_s;
  logic [31:0]      status_s;

  // Store mask, byte offset and upper store data are not needed by this block
  logic             unused_s;
  assign unused_s = &{1'b0, mask, a[1:0], wd[31:16]};

  // Address decode and register-side status
  always_comb begin
    hit        = (a[31:4] == BASE_ADDR[31:4]);
    sel_s      = a[3:2];
    wr_s       = hit && we;
    full_s     = (count_q == CNT_W'(FIFO_DEPTH));
    empty_s    = (count_q == CNT_W'(0));
    busy_s     = (state_q != S_IDLE);
    push_req_s = wr_s && (sel_s == 2'd0);
    ovf_clr_s  = wr_s && (sel_s == 2'd1) && wd[3];
    status_s   = {16'd0, 8'(count_q), 4'd0, ovf_q, busy_s, empty_s, full_s};
  end

  // Combinational read mux, zero outside the window
  always_comb begin
    rd = 32'd0;
    if (hit) begin
      case (sel_s)
        2'd0:    rd = 32'd0;
        2'd1:    rd = status_s;
        2'd2:    rd = {31'd0, en_q};
        2'd3:    rd = {16'd0, div_q};
        default: rd = 32'd0;
      endcase
    end else begin
      rd = 32'd0;
    end
  end

  // Serialiser next state; pops the FIFO when a new frame starts
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = clk_cnt_q;
    tx_d      = tx_q;
    pop_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_q && !empty_s) begin
          pop_s     = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          tx_d      = 1'b0;
          clk_cnt_d = div_q;
          state_d   = S_START;
        end else begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (clk_cnt_q == 16'd0) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = 3'd0;
          clk_cnt_d = div_q;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == 16'd0) begin
          clk_cnt_d = div_q;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == 16'd0) begin
          // Back-to-back frames: next start bit follows the stop bit directly
          if (en_q && !empty_s) begin
            pop_s     = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            tx_d      = 1'b0;
            clk_cnt_d = div_q;
            state_d   = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO, overflow and control register next state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // A push into a full FIFO is still accepted when a pop frees a slot on the same edge
    push_acc_s = push_req_s && (!full_s || pop_s);
    if (push_acc_s) begin
      mem_d[wr_ptr_q] = wd[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_acc_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Setting overflow takes priority over a same-edge clear
    if (push_req_s && !push_acc_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (wr_s && (sel_s == 2'd2)) begin
      en_d = wd[0];
    end else begin
      en_d = en_q;
    end
    if (wr_s && (sel_s == 2'd3)) begin
      div_d = wd[15:0];
    end else begin
      div_d = div_q;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control, pointer and serialiser state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      en_q      <= 1'b1;
      div_q     <= DEFAULT_DIV;
      state_q   <= S_IDLE;
      shift_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      clk_cnt_q <= 16'd0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      en_q      <= en_d;
      div_q     <= div_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      clk_cnt_q <= clk_cnt_d;
      tx_q      <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stimulus with a scoreboard; a UART receiver monitor
// decodes tx frames and compares each byte against the queue of expected bytes.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [3:0]  mask;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;
  logic        tx;

  int          n_checks;
  int          n_err;
  int          cyc;
  logic        mon_en;
  logic [15:0] mon_div;
  logic [7:0]  exp_q[$];
  int          start_q[$];

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .mask(mask),
    .we  (we),
    .wd  (wd),
    .rd  (rd),
    .hit (hit),
    .tx  (tx)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for frame-spacing measurements
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_addr(input logic [31:0] addr, input logic [31:0] d);
    a  = addr;
    wd = d;
    we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    wr_addr(BASE + {28'd0, off}, d);
  endtask

  task automatic store(input logic [7:0] b, input bit expect_tx);
    wr(4'h0, {24'd0, b});
    if (expect_tx) exp_q.push_back(b);
  endtask

  task automatic rdchk(input logic [3:0] off, input logic [31:0] exp, input string name);
    a  = BASE + {28'd0, off};
    we = 1'b0;
    #1;
    chk(name, rd, exp);
  endtask

  // Monitor: decode 8N1 frames on tx and compare against the expected-byte queue
  initial begin
    int L;
    logic [7:0] rx;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst && tx === 1'b0) begin
        L = int'(mon_div) + 1;
        start_q.push_back(cyc);
        repeat (L / 2) step();
        chk("mon_start", {31'd0, tx}, 32'd0);
        rx = 8'd0;
        for (int k = 0; k < 8; k++) begin
          repeat (L) step();
          rx[k] = tx;
        end
        repeat (L) step();
        chk("mon_stop", {31'd0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL mon_unexpected: got byte %h expected no frame", rx);
        end else begin
          chk("mon_byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
        end
        repeat (L - L / 2 - 1) step();
      end
    end
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    bit done;
    bit saw_low;
    logic [7:0] b;
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    a        = 32'd0;
    mask     = 4'hF;
    we       = 1'b0;
    wd       = 32'd0;
    mon_en   = 1'b1;
    mon_div  = 16'd15;
    step();
    step();
    rst = 1'b0;

    // T1: reset state
    rdchk(4'h4, 32'h0000_0002, "t1_status");
    rdchk(4'h8, 32'h0000_0001, "t1_ctrl");
    rdchk(4'hC, 32'h0000_000F, "t1_div");
    chk("t1_tx", {31'd0, tx}, 32'd1);
    a = BASE + 32'h10;
    #1;
    chk("t1_hit", {31'd0, hit}, 32'd0);
    chk("t1_rd", rd, 32'd0);

    // T2: DIVISOR=3, single 0x55 frame, exact waveform and busy
    step();
    wr(4'hC, 32'd3);
    mon_div = 16'd3;
    store(8'h55, 1'b1);
    a = BASE + 32'h4;
    b = 8'h55;
    for (int i = 0; i < 40; i++) begin
      logic e;
      step();
      if (i < 4) e = 1'b0;
      else if (i < 36) e = b[(i - 4) / 4];
      else e = 1'b1;
      chk("t2_tx", {31'd0, tx}, {31'd0, e});
      chk("t2_busy", {31'd0, rd[2]}, 32'd1);
    end
    step();
    chk("t2_idle", {31'd0, rd[2]}, 32'd0);

    // T3: disabled, overfill, clear overflow, then drain 8 frames
    wr(4'h8, 32'd0);
    for (int i = 0; i < 9; i++) store(8'h10 + 8'(i), i < 8);
    rdchk(4'h4, 32'h0000_0809, "t3_status_full");
    chk("t3_tx_idle", {31'd0, tx}, 32'd1);
    step();
    wr(4'h4, 32'h8);
    rdchk(4'h4, 32'h0000_0801, "t3_status_ovf_clr");
    step();
    wr(4'h8, 32'd1);
    a = BASE + 32'h4;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      step();
      if (rd[1] && !rd[2]) done = 1'b1;
    end
    chk("t3_drained", {31'd0, done}, 32'd1);
    chk("t3_queue_empty", exp_q.size(), 32'd0);

    // T4: DIVISOR=0, two back-to-back frames with no idle gap
    wr(4'hC, 32'd0);
    mon_div = 16'd0;
    start_q.delete();
    store(8'hA5, 1'b1);
    store(8'h3C, 1'b1);
    repeat (40) step();
    chk("t4_frames", start_q.size(), 32'd2);
    if (start_q.size() == 2) chk("t4_gap", start_q[1] - start_q[0], 32'd10);
    chk("t4_queue_empty", exp_q.size(), 32'd0);

    // T5: reset during DATA bit 4 aborts the frame
    mon_en = 1'b0;
    wr(4'hC, 32'd3);
    mon_div = 16'd3;
    store(8'hFF, 1'b0);
    step();
    chk("t5_start_low", {31'd0, tx}, 32'd0);
    repeat (21) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_tx", {31'd0, tx}, 32'd1);
    rdchk(4'h4, 32'h0000_0002, "t5_status");
    rdchk(4'hC, 32'h0000_000F, "t5_div");
    saw_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    chk("t5_no_resume", {31'd0, saw_low}, 32'd0);

    // T6: stores outside the window are ignored
    wr_addr(BASE - 32'd4, 32'h77);
    chk("t6_hit_below", {31'd0, hit}, 32'd0);
    wr_addr(BASE + 32'h10, 32'h77);
    chk("t6_hit_above", {31'd0, hit}, 32'd0);
    rdchk(4'h4, 32'h0000_0002, "t6_status");

    // T6: DIVISOR 3 -> 1 written during START applies from bit 0
    step();
    wr(4'hC, 32'd3);
    store(8'h0F, 1'b0);
    step();
    chk("t6_start0", {31'd0, tx}, 32'd0);
    wr(4'hC, 32'd1);
    chk("t6_start1", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t6_start", {31'd0, tx}, 32'd0);
    end
    b = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 2; r++) begin
        step();
        chk("t6_bit", {31'd0, tx}, {31'd0, b[k]});
      end
    end
    for (int r = 0; r < 2; r++) begin
      step();
      chk("t6_stop", {31'd0, tx}, 32'd1);
    end
    step();
    a = BASE + 32'h4;
    #1;
    chk("t6_idle", {31'd0, rd[2]}, 32'd0);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
